// File: rtl/chan_mux_pkg.sv
// Shared types and constants for the chan_mux_rr channel multiplexer.
package chan_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  localparam int XFER_CNT_W = 16;

endpackage

// File: rtl/chan_mux_rr_pick.sv
// rr_pick: combinational rotate-priority search, first set req bit at or after base (wrapping).
module rr_pick #(
  parameter  int N     = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] base,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    int c;
    found = 1'b0;
    idx   = '0;
    c     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      c = int'(base) + i;
      if (c >= N) c = c - N;
      if (req[c]) begin
        found = 1'b1;
        idx   = SEL_W'(c);
      end
    end
  end

endmodule

// File: rtl/chan_mux_rr.sv
// chan_mux_rr: registered N:1 channel mux with valid/ready, fixed or round-robin select.
// Optional transfer counter port xfer_cnt when CHAN_MUX_STATS_EN is defined.
module chan_mux_rr
  import chan_mux_pkg::*;
#(
  parameter  int N_CH  = 8,
  parameter  int W     = 1,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*W-1:0]     in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  output logic [W-1:0]          out_data,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef CHAN_MUX_STATS_EN
  ,
  output logic [XFER_CNT_W-1:0] xfer_cnt
`endif
);

  logic [W-1:0]      r_out_data;
  logic [SEL_W-1:0]  r_out_ch;
  logic              r_out_valid;
  logic [SEL_W-1:0]  r_ptr;

  logic              w_is_rr;
  logic              w_rr_found;
  logic [SEL_W-1:0]  w_rr_idx;
  logic              w_sel_ok;
  logic [N_CH-1:0]   w_sel_bits;
  logic              w_fixed_grant;
  logic              w_grant;
  logic [SEL_W-1:0]  w_g;
  logic              w_can_accept;
  logic              w_accept;
  logic [N_CH*W-1:0] w_shifted;
  logic [W-1:0]      w_data;

  assign w_is_rr = (mode_e'(mode) == MODE_RR);

  rr_pick #(.N(N_CH)) u_rr_pick (
    .req   (in_valid),
    .base  (r_ptr),
    .found (w_rr_found),
    .idx   (w_rr_idx)
  );

  // Shift rather than index so an out-of-range sel simply reads as no request.
  assign w_sel_ok      = ({1'b0, sel} < (SEL_W + 1)'(N_CH));
  assign w_sel_bits    = in_valid >> sel;
  assign w_fixed_grant = w_sel_ok && w_sel_bits[0];

  assign w_grant      = w_is_rr ? w_rr_found : w_fixed_grant;
  assign w_g          = w_is_rr ? w_rr_idx : sel;
  assign w_can_accept = !r_out_valid || out_ready;
  assign w_accept     = rst_n && w_can_accept && w_grant;

  assign in_ready  = w_accept ? (N_CH'(1) << w_g) : '0;
  assign w_shifted = in_data >> (int'(w_g) * W);
  assign w_data    = w_shifted[W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_ptr       <= '0;
    end else begin
      if (w_accept) begin
        r_out_data  <= w_data;
        r_out_ch    <= w_g;
        r_out_valid <= 1'b1;
        if (w_is_rr) begin
          r_ptr <= (w_g == SEL_W'(N_CH - 1)) ? '0 : w_g + 1'b1;
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef CHAN_MUX_STATS_EN
  logic [XFER_CNT_W-1:0] r_xfer_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_xfer_cnt <= '0;
    end else if (w_accept && (r_xfer_cnt != {XFER_CNT_W{1'b1}})) begin
      r_xfer_cnt <= r_xfer_cnt + 1'b1;
    end
  end

  assign xfer_cnt = r_xfer_cnt;
`endif

  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_chan_mux_rr.sv
// Directed self-checking bench for chan_mux_rr (8-channel and 5-channel instances, W=1).
module tb_chan_mux_rr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data, in_valid, in_ready;
  logic       mode;
  logic [2:0] sel;
  logic [0:0] out_data;
  logic [2:0] out_ch;
  logic       out_valid, out_ready;

  logic [4:0] in_data5, in_valid5, in_ready5;
  logic       mode5;
  logic [2:0] sel5;
  logic [0:0] out_data5;
  logic [2:0] out_ch5;
  logic       out_valid5, out_ready5;

`ifdef CHAN_MUX_STATS_EN
  logic [15:0] xfer_cnt, xfer_cnt5;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  chan_mux_rr #(.N_CH(8), .W(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
`ifdef CHAN_MUX_STATS_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  chan_mux_rr #(.N_CH(5), .W(1)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data5), .in_valid(in_valid5),
    .in_ready(in_ready5), .mode(mode5), .sel(sel5), .out_data(out_data5),
    .out_ch(out_ch5), .out_valid(out_valid5), .out_ready(out_ready5)
`ifdef CHAN_MUX_STATS_EN
    , .xfer_cnt(xfer_cnt5)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 8'hFF; in_data = 8'h00; mode = 1'b1; sel = 3'd0; out_ready = 1'b1;
    in_valid5 = 5'h00; in_data5 = 5'h00; mode5 = 1'b0; sel5 = 3'd0; out_ready5 = 1'b1;
    step(); step();
    checks++; if (in_ready !== 8'h00) begin failures++; $display("FAIL reset_in_ready got=%h exp=00", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_ch !== 3'd0) begin failures++; $display("FAIL reset_out_ch got=%0d exp=0", out_ch); end
    checks++; if (out_data !== 1'b0) begin failures++; $display("FAIL reset_out_data got=%b exp=0", out_data); end
    rst_n = 1'b1; #1;
    checks++; if (in_ready !== 8'h01) begin failures++; $display("FAIL reset_first_grant got=%h exp=01", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_ch !== 3'd0) begin failures++; $display("FAIL reset_first_out got=%b/%0d exp=1/0", out_valid, out_ch); end
  endtask

  task automatic test_fixed();
    mode = 1'b0; in_data = 8'b01100011; in_valid = 8'hFF; sel = 3'd2; #1;
    checks++; if (in_ready !== 8'b00000100) begin failures++; $display("FAIL fixed2_in_ready got=%b exp=00000100", in_ready); end
    step();
    checks++; if (out_data !== 1'b0 || out_ch !== 3'd2) begin failures++; $display("FAIL fixed2_out got=%b/%0d exp=0/2", out_data, out_ch); end
    sel = 3'd5; #1;
    checks++; if (in_ready !== 8'b00100000) begin failures++; $display("FAIL fixed5_in_ready got=%b exp=00100000", in_ready); end
    step();
    checks++; if (out_data !== 1'b1 || out_ch !== 3'd5) begin failures++; $display("FAIL fixed5_out got=%b/%0d exp=1/5", out_data, out_ch); end
  endtask

  task automatic test_rr_fair();
    int seq[3] = '{1, 4, 7};
    mode = 1'b1; in_valid = 8'b10010010; in_data = 8'h00; #1;
    for (int i = 0; i < 6; i++) begin
      checks++; if (in_ready !== (8'h01 << seq[i % 3])) begin failures++; $display("FAIL rr_in_ready[%0d] got=%b exp_ch=%0d", i, in_ready, seq[i % 3]); end
      step();
      checks++; if (out_valid !== 1'b1 || out_ch !== 3'(seq[i % 3])) begin failures++; $display("FAIL rr_out_ch[%0d] got=%b/%0d exp=1/%0d", i, out_valid, out_ch, seq[i % 3]); end
    end
    in_valid = 8'h00; step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rr_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    in_valid = 8'h08; in_data = 8'h08; #1;
    checks++; if (in_ready !== 8'h08) begin failures++; $display("FAIL bp_grant3 got=%h exp=08", in_ready); end
    step();
    checks++; if (out_ch !== 3'd3 || out_data !== 1'b1) begin failures++; $display("FAIL bp_out3 got=%0d/%b exp=3/1", out_ch, out_data); end
    out_ready = 1'b0; in_valid = 8'h40; in_data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 8'h00) begin failures++; $display("FAIL bp_stall_ready[%0d] got=%h exp=00", i, in_ready); end
      step();
      checks++; if (out_ch !== 3'd3 || out_data !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold[%0d] got=%0d/%b/%b exp=3/1/1", i, out_ch, out_data, out_valid); end
    end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 8'h40) begin failures++; $display("FAIL bp_release_ready got=%h exp=40", in_ready); end
    step();
    checks++; if (out_ch !== 3'd6 || out_data !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_release_out got=%0d/%b/%b exp=6/0/1", out_ch, out_data, out_valid); end
    in_valid = 8'h00; step();
  endtask

  task automatic test_mode_switch();
    in_valid = 8'h04; #1;
    checks++; if (in_ready !== 8'h04) begin failures++; $display("FAIL ms_rr_first got=%h exp=04", in_ready); end
    step();
    mode = 1'b0; sel = 3'd0; in_valid = 8'hFF; #1;
    checks++; if (in_ready !== 8'h01) begin failures++; $display("FAIL ms_fixed got=%h exp=01", in_ready); end
    step();
    mode = 1'b1; in_valid = 8'b00010010; #1;
    checks++; if (in_ready !== 8'h10) begin failures++; $display("FAIL ms_rr_ptr_kept got=%h exp=10", in_ready); end
    step();
    checks++; if (out_ch !== 3'd4) begin failures++; $display("FAIL ms_rr_out got=%0d exp=4", out_ch); end
    in_valid = 8'h00; step();
  endtask

  task automatic test_boundaries();
    mode5 = 1'b0; sel5 = 3'd6; in_valid5 = 5'h1F; in_data5 = 5'b10000; out_ready5 = 1'b1; #1;
    checks++; if (in_ready5 !== 5'h00) begin failures++; $display("FAIL b_sel6_ready got=%b exp=00000", in_ready5); end
    step();
    checks++; if (out_valid5 !== 1'b0) begin failures++; $display("FAIL b_sel6_valid got=%b exp=0", out_valid5); end
    sel5 = 3'd4; #1;
    checks++; if (in_ready5 !== 5'b10000) begin failures++; $display("FAIL b_sel4_ready got=%b exp=10000", in_ready5); end
    step();
    checks++; if (out_valid5 !== 1'b1 || out_ch5 !== 3'd4 || out_data5 !== 1'b1) begin failures++; $display("FAIL b_sel4_out got=%b/%0d/%b exp=1/4/1", out_valid5, out_ch5, out_data5); end
    mode5 = 1'b1; in_valid5 = 5'b01000; #1;
    checks++; if (in_ready5 !== 5'b01000) begin failures++; $display("FAIL b_rr3_ready got=%b exp=01000", in_ready5); end
    step();
    in_valid5 = 5'b10000; #1;
    checks++; if (in_ready5 !== 5'b10000) begin failures++; $display("FAIL b_rr4_ready got=%b exp=10000", in_ready5); end
    step();
    checks++; if (out_ch5 !== 3'd4) begin failures++; $display("FAIL b_rr4_out got=%0d exp=4", out_ch5); end
    in_valid5 = 5'b10001; #1;
    checks++; if (in_ready5 !== 5'b00001) begin failures++; $display("FAIL b_ptr_wrap got=%b exp=00001", in_ready5); end
    step();
    checks++; if (out_ch5 !== 3'd0) begin failures++; $display("FAIL b_wrap_out got=%0d exp=0", out_ch5); end
    in_valid5 = 5'h00; step();
  endtask

  task automatic test_reset_mid_transfer();
    mode = 1'b1; in_valid = 8'h01; in_data = 8'h01; out_ready = 1'b1; #1;
    checks++; if (in_ready !== 8'h01) begin failures++; $display("FAIL rm_grant got=%h exp=01", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 1'b1) begin failures++; $display("FAIL rm_loaded got=%b/%b exp=1/1", out_valid, out_data); end
    out_ready = 1'b0; in_valid = 8'hFF; rst_n = 1'b0; #1;
    checks++; if (in_ready !== 8'h00) begin failures++; $display("FAIL rm_ready_in_reset got=%h exp=00", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0 || out_data !== 1'b0 || out_ch !== 3'd0) begin failures++; $display("FAIL rm_cleared got=%b/%b/%0d exp=0/0/0", out_valid, out_data, out_ch); end
    rst_n = 1'b1; in_valid = 8'h00; out_ready = 1'b1;
  endtask

`ifdef CHAN_MUX_STATS_EN
  task automatic test_stats();
    checks++; if (xfer_cnt !== 16'd0) begin failures++; $display("FAIL stats_reset got=%0d exp=0", xfer_cnt); end
    mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    repeat (10) step();
    in_valid = 8'h00; step();
    checks++; if (xfer_cnt !== 16'd10) begin failures++; $display("FAIL stats_count got=%0d exp=10", xfer_cnt); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fixed();
    test_rr_fair();
    test_backpressure();
    test_mode_switch();
    test_boundaries();
    test_reset_mid_transfer();
`ifdef CHAN_MUX_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
